// File: rtl/mmt_sync_pkg.sv
// Shared definitions for the multi-channel synchroniser / glitch filter:
// parameter legality checks and the filter counter width helper.
package mmt_sync_pkg;

    // Width of a counter that must hold the values 0 .. filter_len.
    function automatic int cnt_width(input int filter_len);
        return $clog2(filter_len + 32'sd1);
    endfunction

    // True when the synchroniser parameters describe a buildable block.
    function automatic bit params_legal(
        input int width,
        input int depth,
        input int filter_len,
        input int inject_delay
    );
        return (width >= 32'sd1) &&
               (depth >= 32'sd2) &&
               (filter_len >= 32'sd1) &&
               ((inject_delay == 32'sd0) || (inject_delay == 32'sd1));
    endfunction

endpackage

// File: rtl/mmt_sync_filter_ch.sv
// One channel: flop synchroniser chain followed by a persistence filter.
// `out` only adopts a new synchronised level after it has been seen on
// FILTER_LEN consecutive edges; rise/fall pulse on the edge `out` moves.
module mmt_sync_filter_ch
    import mmt_sync_pkg::*;
#(
    parameter int   DEPTH        = 3,
    parameter int   FILTER_LEN   = 4,
    parameter int   INJECT_DELAY = 0,
    parameter logic RESET_VAL    = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic in,
    output logic out,
    output logic rise,
    output logic fall
);

    localparam int STAGES = DEPTH + INJECT_DELAY;
    localparam int CW     = cnt_width(FILTER_LEN);
    localparam logic [CW-1:0] CNT_LAST = CW'(FILTER_LEN - 1);

    logic [STAGES-1:0] chain_r;
    logic              sync_s;
    logic [CW-1:0]     cnt_r;
    logic              out_r;
    logic              rise_r;
    logic              fall_r;

    // Synchroniser chain: stage 0 samples the asynchronous input, last stage feeds the filter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            chain_r <= {STAGES{RESET_VAL}};
        end else begin
            chain_r <= {chain_r[STAGES-2:0], in};
        end
    end

    assign sync_s = chain_r[STAGES-1];

    // Persistence filter: count consecutive disagreements, commit on the FILTER_LEN-th one.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_r  <= '0;
            out_r  <= RESET_VAL;
            rise_r <= 1'b0;
            fall_r <= 1'b0;
        end else if (sync_s == out_r) begin
            // Agreement (or a glitch that ended) discards any partial count.
            cnt_r  <= '0;
            rise_r <= 1'b0;
            fall_r <= 1'b0;
        end else if (cnt_r == CNT_LAST) begin
            out_r  <= sync_s;
            cnt_r  <= '0;
            rise_r <= sync_s;
            fall_r <= ~sync_s;
        end else begin
            cnt_r  <= cnt_r + CW'(1);
            rise_r <= 1'b0;
            fall_r <= 1'b0;
        end
    end

    assign out  = out_r;
    assign rise = rise_r;
    assign fall = fall_r;

endmodule

// File: rtl/mmt_sync_multi.sv
// Multi-channel synchroniser with glitch filter and edge pulses.
// Each channel is independent; `changed` flags any registered edge pulse.
module mmt_sync_multi
    import mmt_sync_pkg::*;
#(
    parameter int               WIDTH        = 8,
    parameter int               DEPTH        = 3,
    parameter int               FILTER_LEN   = 4,
    parameter logic [WIDTH-1:0] RESET_VAL    = {WIDTH{1'b0}},
    parameter int               INJECT_DELAY = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in,
    output logic [WIDTH-1:0] out,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall,
    output logic             changed
);

    if (!params_legal(WIDTH, DEPTH, FILTER_LEN, INJECT_DELAY)) begin : g_bad_params
        $error("mmt_sync_multi: illegal WIDTH/DEPTH/FILTER_LEN/INJECT_DELAY");
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_ch
        mmt_sync_filter_ch #(
            .DEPTH        (DEPTH),
            .FILTER_LEN   (FILTER_LEN),
            .INJECT_DELAY (INJECT_DELAY),
            .RESET_VAL    (RESET_VAL[i])
        ) u_ch (
            .clk  (clk),
            .rst  (rst),
            .in   (in[i]),
            .out  (out[i]),
            .rise (rise[i]),
            .fall (fall[i])
        );
    end

    // Any-channel activity flag, built only from the registered pulses.
    assign changed = |(rise | fall);

endmodule

// File: tb/tb_mmt_sync_multi.sv
// Self-checking bench for mmt_sync_multi. Four instances cover the default
// configuration, the delay-fault mode, an all-ones reset value and the
// unfiltered FILTER_LEN=1/DEPTH=2 case. A queue-based model (delay line plus
// a sliding window of the last FILTER_LEN synchronised samples) predicts
// every instance on every edge.
module tb_mmt_sync_multi;

    localparam int         STG [4] = '{3, 4, 3, 2};
    localparam int         FL  [4] = '{4, 4, 4, 1};
    localparam logic [3:0] RV  [4] = '{4'h0, 4'h0, 4'hF, 4'h0};

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] din   [4];
    logic [3:0] dout  [4];
    logic [3:0] drise [4];
    logic [3:0] dfall [4];
    logic       dchg  [4];

    int n_checks = 0;
    int n_errors = 0;

    // model state
    logic [3:0] m_line [4][$];
    logic [3:0] m_win  [4][$];
    logic [3:0] m_out  [4];
    logic [3:0] m_rise [4];
    logic [3:0] m_fall [4];

    always #5 clk = ~clk;

    mmt_sync_multi #(.WIDTH(4), .DEPTH(3), .FILTER_LEN(4), .RESET_VAL(4'h0), .INJECT_DELAY(0)) dut0 (
        .clk(clk), .rst(rst), .in(din[0]), .out(dout[0]), .rise(drise[0]), .fall(dfall[0]), .changed(dchg[0]));
    mmt_sync_multi #(.WIDTH(4), .DEPTH(3), .FILTER_LEN(4), .RESET_VAL(4'h0), .INJECT_DELAY(1)) dut1 (
        .clk(clk), .rst(rst), .in(din[1]), .out(dout[1]), .rise(drise[1]), .fall(dfall[1]), .changed(dchg[1]));
    mmt_sync_multi #(.WIDTH(4), .DEPTH(3), .FILTER_LEN(4), .RESET_VAL(4'hF), .INJECT_DELAY(0)) dut2 (
        .clk(clk), .rst(rst), .in(din[2]), .out(dout[2]), .rise(drise[2]), .fall(dfall[2]), .changed(dchg[2]));
    mmt_sync_multi #(.WIDTH(4), .DEPTH(2), .FILTER_LEN(1), .RESET_VAL(4'h0), .INJECT_DELAY(0)) dut3 (
        .clk(clk), .rst(rst), .in(din[3]), .out(dout[3]), .rise(drise[3]), .fall(dfall[3]), .changed(dchg[3]));

    task automatic model_reset();
        for (int k = 0; k < 4; k++) begin
            m_line[k] = {};
            for (int j = 0; j < STG[k]; j++) m_line[k].push_back(RV[k]);
            m_win[k]  = {};
            m_out[k]  = RV[k];
            m_rise[k] = 4'h0;
            m_fall[k] = 4'h0;
        end
    endtask

    // One clock edge of the model: the value leaving the delay line is the
    // synchronised level; a bit of out flips when the whole window of the
    // last FL samples disagrees with it.
    task automatic model_edge(input int k);
        logic [3:0] s;
        logic [3:0] nout;
        logic [3:0] dummy;
        bit         all_diff;
        s = m_line[k].pop_front();
        m_line[k].push_back(din[k]);
        m_win[k].push_back(s);
        if (m_win[k].size() > FL[k]) dummy = m_win[k].pop_front();
        nout = m_out[k];
        if (m_win[k].size() == FL[k]) begin
            for (int b = 0; b < 4; b++) begin
                all_diff = 1'b1;
                for (int j = 0; j < m_win[k].size(); j++)
                    if (m_win[k][j][b] == m_out[k][b]) all_diff = 1'b0;
                if (all_diff) nout[b] = ~m_out[k][b];
            end
        end
        m_rise[k] = nout & ~m_out[k];
        m_fall[k] = ~nout & m_out[k];
        m_out[k]  = nout;
    endtask

    task automatic tick();
        @(posedge clk);
        if (!rst) begin
            for (int k = 0; k < 4; k++) model_edge(k);
        end
        @(negedge clk);
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b1;
        #1;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        for (int k = 0; k < 4; k++) din[k] = 4'($urandom);
        model_reset();
        @(negedge clk);
        @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            n_checks++;
            if (dout[k] !== RV[k] || drise[k] !== 4'h0 || dfall[k] !== 4'h0 || dchg[k] !== 1'b0) begin
                n_errors++;
                $display("FAIL reset dut%0d got out=%b rise=%b fall=%b chg=%b want out=%b pulses 0",
                         k, dout[k], drise[k], dfall[k], dchg[k], RV[k]);
            end
        end
    endtask

    task automatic test_latency();
        logic [3:0] e_out0, e_rise0, e_out1, e_rise1;
        logic       e_chg0;
        for (int k = 0; k < 4; k++) din[k] = 4'h0;
        apply_reset();
        din[0] = 4'b0001;
        din[1] = 4'b0001;
        for (int n = 1; n <= 9; n++) begin
            tick();
            e_out0  = (n >= 7) ? 4'b0001 : 4'b0000;
            e_rise0 = (n == 7) ? 4'b0001 : 4'b0000;
            e_chg0  = (n == 7);
            e_out1  = (n >= 8) ? 4'b0001 : 4'b0000;
            e_rise1 = (n == 8) ? 4'b0001 : 4'b0000;
            n_checks++;
            if (dout[0] !== e_out0 || drise[0] !== e_rise0 || dchg[0] !== e_chg0) begin
                n_errors++;
                $display("FAIL latency edge %0d got out=%b rise=%b chg=%b want out=%b rise=%b chg=%b",
                         n, dout[0], drise[0], dchg[0], e_out0, e_rise0, e_chg0);
            end
            n_checks++;
            if (dout[1] !== e_out1 || drise[1] !== e_rise1) begin
                n_errors++;
                $display("FAIL latency_inject edge %0d got out=%b rise=%b want out=%b rise=%b",
                         n, dout[1], drise[1], e_out1, e_rise1);
            end
        end
    endtask

    task automatic test_glitch();
        logic [3:0] e_out, e_rise, e_fall;
        din[0] = 4'h0;
        apply_reset();
        for (int n = 1; n <= 8; n++) tick();
        for (int n = 1; n <= 15; n++) begin
            din[0] = (n <= 3) ? 4'b0010 : 4'b0000;
            tick();
            n_checks++;
            if (dout[0] !== 4'h0 || drise[0] !== 4'h0 || dfall[0] !== 4'h0) begin
                n_errors++;
                $display("FAIL glitch3 edge %0d got out=%b rise=%b fall=%b want all 0000",
                         n, dout[0], drise[0], dfall[0]);
            end
        end
        for (int n = 1; n <= 14; n++) begin
            din[0] = (n <= 4) ? 4'b0010 : 4'b0000;
            tick();
            e_out  = (n >= 7 && n < 11) ? 4'b0010 : 4'b0000;
            e_rise = (n == 7) ? 4'b0010 : 4'b0000;
            e_fall = (n == 11) ? 4'b0010 : 4'b0000;
            n_checks++;
            if (dout[0] !== e_out || drise[0] !== e_rise || dfall[0] !== e_fall) begin
                n_errors++;
                $display("FAIL pulse4 edge %0d got out=%b rise=%b fall=%b want out=%b rise=%b fall=%b",
                         n, dout[0], drise[0], dfall[0], e_out, e_rise, e_fall);
            end
        end
    endtask

    task automatic test_multi();
        logic [3:0] e_out, e_rise, e_fall;
        din[0] = 4'b1010;
        for (int n = 1; n <= 8; n++) begin
            tick();
            e_out  = (n >= 7) ? 4'b1010 : 4'b0000;
            e_rise = (n == 7) ? 4'b1010 : 4'b0000;
            n_checks++;
            if (dout[0] !== e_out || drise[0] !== e_rise || dfall[0] !== 4'h0) begin
                n_errors++;
                $display("FAIL multi_up edge %0d got out=%b rise=%b fall=%b want out=%b rise=%b fall=0000",
                         n, dout[0], drise[0], dfall[0], e_out, e_rise);
            end
        end
        din[0] = 4'b0101;
        for (int n = 1; n <= 8; n++) begin
            tick();
            e_out  = (n >= 7) ? 4'b0101 : 4'b1010;
            e_rise = (n == 7) ? 4'b0101 : 4'b0000;
            e_fall = (n == 7) ? 4'b1010 : 4'b0000;
            n_checks++;
            if (dout[0] !== e_out || drise[0] !== e_rise || dfall[0] !== e_fall) begin
                n_errors++;
                $display("FAIL multi_swap edge %0d got out=%b rise=%b fall=%b want out=%b rise=%b fall=%b",
                         n, dout[0], drise[0], dfall[0], e_out, e_rise, e_fall);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [3:0] e_out, e_rise;
        din[0] = 4'h0;
        apply_reset();
        din[0] = 4'b0100;
        for (int n = 1; n <= 4; n++) tick();
        rst = 1'b1;
        #1;
        model_reset();
        n_checks++;
        if (dout[0] !== 4'h0 || drise[0] !== 4'h0 || dchg[0] !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_mid_async got out=%b rise=%b chg=%b want 0000 0000 0",
                     dout[0], drise[0], dchg[0]);
        end
        tick();
        rst = 1'b0;
        for (int n = 1; n <= 9; n++) begin
            tick();
            e_out  = (n >= 7) ? 4'b0100 : 4'b0000;
            e_rise = (n == 7) ? 4'b0100 : 4'b0000;
            n_checks++;
            if (dout[0] !== e_out || drise[0] !== e_rise || dfall[0] !== 4'h0) begin
                n_errors++;
                $display("FAIL reset_mid edge %0d got out=%b rise=%b fall=%b want out=%b rise=%b fall=0000",
                         n, dout[0], drise[0], dfall[0], e_out, e_rise);
            end
        end
    endtask

    task automatic test_reset_val();
        logic [3:0] e_out, e_fall;
        din[2] = 4'hF;
        apply_reset();
        for (int n = 1; n <= 12; n++) begin
            tick();
            n_checks++;
            if (dout[2] !== 4'hF || drise[2] !== 4'h0 || dfall[2] !== 4'h0) begin
                n_errors++;
                $display("FAIL resetval_hold edge %0d got out=%b rise=%b fall=%b want 1111 0000 0000",
                         n, dout[2], drise[2], dfall[2]);
            end
        end
        din[2] = 4'h0;
        apply_reset();
        for (int n = 1; n <= 9; n++) begin
            tick();
            e_out  = (n >= 7) ? 4'h0 : 4'hF;
            e_fall = (n == 7) ? 4'hF : 4'h0;
            n_checks++;
            if (dout[2] !== e_out || drise[2] !== 4'h0 || dfall[2] !== e_fall) begin
                n_errors++;
                $display("FAIL resetval_fall edge %0d got out=%b rise=%b fall=%b want out=%b rise=0000 fall=%b",
                         n, dout[2], drise[2], dfall[2], e_out, e_fall);
            end
        end
    endtask

    task automatic test_filter1();
        logic [3:0] e_out, e_prev;
        int m;
        din[3] = 4'h0;
        apply_reset();
        for (int n = 1; n <= 14; n++) begin
            din[3] = (n % 2 == 1) ? 4'b1000 : 4'b0000;
            tick();
            m = n - 2;
            e_out  = (m >= 1 && m % 2 == 1) ? 4'b1000 : 4'b0000;
            e_prev = (m >= 2 && (m - 1) % 2 == 1) ? 4'b1000 : 4'b0000;
            n_checks++;
            if (dout[3] !== e_out || drise[3] !== (e_out & ~e_prev) || dfall[3] !== (~e_out & e_prev)) begin
                n_errors++;
                $display("FAIL filter1 edge %0d got out=%b rise=%b fall=%b want out=%b rise=%b fall=%b",
                         n, dout[3], drise[3], dfall[3], e_out, e_out & ~e_prev, ~e_out & e_prev);
            end
        end
    endtask

    task automatic test_random();
        logic e_chg;
        for (int it = 0; it < 600; it++) begin
            for (int k = 0; k < 4; k++)
                if ($urandom_range(0, 3) == 0) din[k] = 4'($urandom);
            if ($urandom_range(0, 149) == 0) begin
                #2;
                rst = 1'b1;
                #1;
                model_reset();
                for (int k = 0; k < 4; k++) begin
                    n_checks++;
                    if (dout[k] !== RV[k] || dchg[k] !== 1'b0) begin
                        n_errors++;
                        $display("FAIL rand_async_reset dut%0d got out=%b chg=%b want out=%b chg=0",
                                 k, dout[k], dchg[k], RV[k]);
                    end
                end
                tick();
                rst = 1'b0;
            end else begin
                tick();
                for (int k = 0; k < 4; k++) begin
                    e_chg = |(m_rise[k] | m_fall[k]);
                    n_checks++;
                    if (dout[k] !== m_out[k] || drise[k] !== m_rise[k] || dfall[k] !== m_fall[k] ||
                        dchg[k] !== e_chg || (drise[k] & dfall[k]) !== 4'h0) begin
                        n_errors++;
                        $display("FAIL random it %0d dut%0d got out=%b rise=%b fall=%b chg=%b want out=%b rise=%b fall=%b chg=%b",
                                 it, k, dout[k], drise[k], dfall[k], dchg[k], m_out[k], m_rise[k], m_fall[k], e_chg);
                    end
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_latency();
        test_glitch();
        test_multi();
        test_reset_mid();
        test_reset_val();
        test_filter1();
        test_random();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/mmt_sync_multi.md
MMT_SYNC_MULTI -- requirements
Module: mmt_sync_multi

Interface
REQ-001 Parameter WIDTH, default 8: number of independent channels, at least 1.
REQ-002 Parameter DEPTH, default 3: synchroniser flop stages per channel, at least 2.
REQ-003 Parameter FILTER_LEN, default 4: consecutive cycles a new synchronised value must persist before `out` accepts it, at least 1.
REQ-004 Parameter RESET_VAL, default all-zeros (WIDTH bits): reset value of every stage and of `out`, per channel.
REQ-005 Parameter INJECT_DELAY, default 0: 1 inserts one extra flop ahead of the chain (delay-fault mode); 0 omits it.
REQ-006 Ports SHALL be, in order:
- clk, input, 1 bit: the only clock; all state changes on its rising edge.
- rst, input, 1 bit: asynchronous, active-high reset.
- in, input, WIDTH bits: asynchronous channel inputs.
- out, output, WIDTH bits: synchronised and filtered levels.
- rise, output, WIDTH bits: one-cycle pulse when `out[i]` goes 0->1.
- fall, output, WIDTH bits: one-cycle pulse when `out[i]` goes 1->0.
- changed, output, 1 bit: OR-reduction of rise|fall.

Function
REQ-007 Per channel, SHALL have a chain of DEPTH+INJECT_DELAY flops; stage 0 samples `in[i]`; the last stage is `s[i]`.
REQ-008 Per channel, SHALL have a counter `cnt[i]` of width $clog2(FILTER_LEN+1) with these rules:
- `s[i]==out[i]`: `cnt[i]`<=0.
- Otherwise, if `cnt[i]==FILTER_LEN-1`: `out[i]`<=`s[i]` and `cnt[i]`<=0.
- Otherwise: `cnt[i]`<=`cnt[i]`+1.
REQ-009 FILTER_LEN=1 SHALL give `out[i]` = `s[i]` delayed by exactly one cycle, with no filtering.
REQ-010 Latency: a new input level first sampled at edge 1 and held SHALL appear on `out[i]` after edge DEPTH+INJECT_DELAY+FILTER_LEN.
REQ-011 Glitch: a deviation at `s[i]` lasting fewer than FILTER_LEN cycles SHALL leave `out[i]` unchanged, SHALL produce no rise/fall, and SHALL return `cnt[i]` to 0.
REQ-012 An interrupted deviation SHALL restart the count from 0; there SHALL be no accumulation across glitches.
REQ-013 `rise[i]`/`fall[i]` SHALL be registered and set on the same edge that `out[i]` updates, high for exactly one cycle.
REQ-014 `rise[i]` and `fall[i]` SHALL never be high simultaneously.
REQ-015 Successive toggles that each persist FILTER_LEN cycles SHALL each produce a pulse; no transition SHALL be dropped or merged.
REQ-016 Channels SHALL be fully independent; simultaneous transitions on several channels SHALL yield simultaneous pulses.
REQ-017 `changed` SHALL be combinational from registered rise/fall.
REQ-018 Counters SHALL never exceed FILTER_LEN-1 and SHALL never wrap.

Reset
REQ-019 While rst=1, SHALL hold all chain stages and `out` at RESET_VAL, all `cnt` at 0, and rise, fall, changed at 0, asynchronously.
REQ-020 On rst deassertion, the first active edge SHALL sample `in`; no pulse SHALL appear before a full REQ-010 latency.
REQ-021 If `in` differs from RESET_VAL at release, exactly one pulse per differing channel SHALL follow after the REQ-010 latency.
REQ-022 Reset asserted mid-count SHALL discard the pending transition; no pulse SHALL be emitted for it after release.

Structure
REQ-023 Package mmt_sync_pkg SHALL hold parameter-legality checks (DEPTH>=2, FILTER_LEN>=1, INJECT_DELAY in {0,1}) and the counter-width helper function.
REQ-024 Sub-module mmt_sync_filter_ch SHALL implement one channel (chain, counter, out, rise, fall); the top SHALL be a generate loop over WIDTH plus the `changed` OR.
REQ-025 No combinational path SHALL exist from `in` to any output.

Verification
(Defaults unless stated; WIDTH=4, DEPTH=3, FILTER_LEN=4.)
REQ-026 Latency: release reset with `in`=0000, raise `in[0]` before edge 1 and hold -> `out`=0001, rise=0001, changed=1 for one cycle after edge 7; with INJECT_DELAY=1 -> after edge 8.
REQ-027 Glitch: `in[1]` high for 3 cycles then low -> `out` stays 0000, no pulses; high for 4 cycles -> rise[1] at T+7 and fall[1] exactly 4 cycles later.
REQ-028 Multi-channel: `in` 0000->1010 on one edge -> rise=1010 in a single cycle; later 1010->0101 -> rise=0101 and fall=1010 in the same cycle.
REQ-029 Reset mid-count: `in[2]` raised, rst pulsed at edge 5, `in[2]` held high -> no pulse before release, then rise[2] 7 edges after release.
REQ-030 Reset value: RESET_VAL=1111 with `in`=1111 across release -> `out`=1111 and no pulses; the same with `in`=0000 -> fall=1111 once, 7 edges after release.
REQ-031 FILTER_LEN=1, DEPTH=2: a toggle of `in[3]` every cycle -> `out[3]` follows with 3-edge latency and a pulse every cycle.
